// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the hazard scoreboard.
// Entry layout, forward encoding and stage indices.
package cpu_pipe_pkg;

    localparam int SB_ADDR_W = 8;

    localparam int FWD_RF = 0;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic                 is_load;
        logic [SB_ADDR_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode-side bundle between the decoder and the hazard scoreboard.
// Stats ports exist only when HAZARD_STATS_EN is defined.
interface pipe_hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int STAGES = 3
);
    localparam int FWD_W = $clog2(STAGES + 1);

    logic              id_valid;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [ADDR_W-1:0] id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    logic              flush;
    logic              stall;
    logic              id_issue;
    logic [FWD_W-1:0]  fwd_a;
    logic [FWD_W-1:0]  fwd_b;
    logic [STAGES-1:0] stage_valid;
`ifdef HAZARD_STATS_EN
    logic [31:0]       stall_count;
    logic [31:0]       flush_count;
`endif

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_rd_we, id_is_load, flush,
`ifdef HAZARD_STATS_EN
        input  stall_count, flush_count,
`endif
        input  stall, id_issue, fwd_a, fwd_b, stage_valid
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_rd_we, id_is_load, flush,
`ifdef HAZARD_STATS_EN
        output stall_count, flush_count,
`endif
        output stall, id_issue, fwd_a, fwd_b, stage_valid
    );

endinterface

// File: rtl/fwd_select.sv
// Per-operand forward source and load-use hazard detection.
// The youngest live matching entry decides; older ones are shadowed.
module fwd_select
    import cpu_pipe_pkg::*;
#(
    parameter int ADDR_W           = 5,
    parameter int STAGES           = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int FWD_W            = 2
) (
    input  sb_entry_t [STAGES-1:0] entries,
    input  logic [ADDR_W-1:0]      rs,
    input  logic                   used,
    output logic [FWD_W-1:0]       fwd,
    output logic                   hazard
);

    // Scan oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        fwd    = FWD_W'(FWD_RF);
        hazard = 1'b0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            if (used && entries[s].valid && entries[s].we &&
                entries[s].rd != '0 &&
                entries[s].rd == SB_ADDR_W'(rs)) begin
                if (!entries[s].is_load || s >= LOAD_READY_STAGE) begin
                    fwd    = FWD_W'(s + 1);
                    hazard = 1'b0;
                end else begin
                    fwd    = FWD_W'(FWD_RF);
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Scoreboard of in-flight destinations driving forwarding and stalls.
// Optional HAZARD_STATS_EN adds saturating stall/flush counters.
module pipe_hazard_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int ADDR_W           = 5,
    parameter int STAGES           = 3,
    parameter int LOAD_READY_STAGE = 1
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_N,
    pipe_hazard_scoreboard_if.slave  bus
);

    localparam int FWD_W = $clog2(STAGES + 1);

    sb_entry_t [STAGES-1:0] sb_q;
    sb_entry_t              dec_entry;
    logic                   hazard_a;
    logic                   hazard_b;
    logic                   stall;
    logic                   id_issue;
    logic [FWD_W-1:0]       fwd_a;
    logic [FWD_W-1:0]       fwd_b;
    logic [STAGES-1:0]      stage_valid;

    fwd_select #(
        .ADDR_W           (ADDR_W),
        .STAGES           (STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .FWD_W            (FWD_W)
    ) u_fwd_a (
        .entries (sb_q),
        .rs      (bus.id_rs1),
        .used    (bus.id_rs1_used),
        .fwd     (fwd_a),
        .hazard  (hazard_a)
    );

    fwd_select #(
        .ADDR_W           (ADDR_W),
        .STAGES           (STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .FWD_W            (FWD_W)
    ) u_fwd_b (
        .entries (sb_q),
        .rs      (bus.id_rs2),
        .used    (bus.id_rs2_used),
        .fwd     (fwd_b),
        .hazard  (hazard_b)
    );

    // Issue control: a flush overrides any pending load-use stall.
    always_comb begin
        stall    = bus.id_valid && (hazard_a || hazard_b) && !bus.flush;
        id_issue = bus.id_valid && !stall && !bus.flush;
        dec_entry         = '0;
        dec_entry.valid   = 1'b1;
        dec_entry.we      = bus.id_rd_we;
        dec_entry.is_load = bus.id_is_load;
        dec_entry.rd      = SB_ADDR_W'(bus.id_rd);
        for (int s = 0; s < STAGES; s++) begin
            stage_valid[s] = sb_q[s].valid;
        end
    end

    // Advance the pipeline; a flush kills the EX entry on its way to MEM.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sb_q <= '0;
        end else begin
            for (int s = STAGES - 1; s >= 1; s--) begin
                if (s == 1 && bus.flush) begin
                    sb_q[s] <= '0;
                end else begin
                    sb_q[s] <= sb_q[s-1];
                end
            end
            sb_q[0] <= id_issue ? dec_entry : '0;
        end
    end

    assign bus.stall       = stall;
    assign bus.id_issue    = id_issue;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.stage_valid = stage_valid;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (bus.flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = flush_cnt;
`endif

endmodule
